// File: rtl/i4004_bus_master_pkg.sv
// Shared definitions for the 4004-side bus master: phase encodings, cycle state
// and the helpers that map an address onto the three address phases.
package i4004_bus_master_pkg;

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } bus_state_e;

    // Nibble order on the bus: low address nibble goes out first.
    localparam int unsigned NIB_A1_LSB = 0;
    localparam int unsigned NIB_A2_LSB = 4;
    localparam int unsigned NIB_A3_LSB = 8;

    function automatic logic [3:0] addr_nibble(input logic [11:0] addr, input phase_e ph);
        logic [3:0] nib;
        case (ph)
            PH_A1:   nib = addr[NIB_A1_LSB +: 4];
            PH_A2:   nib = addr[NIB_A2_LSB +: 4];
            PH_A3:   nib = addr[NIB_A3_LSB +: 4];
            default: nib = 4'd0;
        endcase
        return nib;
    endfunction

    function automatic phase_e next_phase(input phase_e ph);
        return phase_e'(ph + 3'd1);
    endfunction

endpackage

// File: rtl/i4004_bus_master_phase_gen.sv
// Bus phase sequencer: PHASE_DIV clock divider plus the free-running 8-phase counter.
// The first tick after reset re-enters A1 so it can serve as a cycle boundary.
module i4004_phase_gen
    import i4004_bus_master_pkg::*;
#(
    parameter int PHASE_DIV = 1
) (
    input  logic   CLK,
    input  logic   RESET,
    output phase_e phase,
    output logic   tick,
    output logic   last_clk,
    output logic   wrap
);

    localparam int DIV_W = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PHASE_DIV - 1);

    logic [DIV_W-1:0] div_r;
    phase_e           phase_r;
    logic             first_r;
    logic             tick_s;

    assign tick_s   = (div_r == DIV_LAST);
    assign tick     = tick_s;
    assign last_clk = tick_s;
    assign phase    = phase_r;
    assign wrap     = tick_s && (first_r || (phase_r == PH_X3));

    // Divider and phase counter; phase holds at A1 through the post-reset lead-in.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_r   <= {DIV_W{1'b0}};
            phase_r <= PH_A1;
            first_r <= 1'b1;
        end else if (tick_s) begin
            div_r   <= {DIV_W{1'b0}};
            phase_r <= first_r ? PH_A1 : next_phase(phase_r);
            first_r <= 1'b0;
        end else begin
            div_r   <= div_r + DIV_W'(1'b1);
            phase_r <= phase_r;
            first_r <= first_r;
        end
    end

endmodule

// File: rtl/i4004_bus_master.sv
// 4004-side initiator for the multiplexed 4-bit ROM bus: accepts requests at cycle
// boundaries, drives address/port-write nibbles and captures the returned OPR/OPA word.
module i4004_bus_master
    import i4004_bus_master_pkg::*;
#(
    parameter int PHASE_DIV = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req,
    input  logic        wr,
    input  logic [11:0] addr,
    input  logic [3:0]  wdata,
    output logic        ack,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        sync,
    output logic        cm_rom,
    output logic [3:0]  data_out,
    output logic        data_oe,
    input  logic [3:0]  data_in
);

    phase_e      phase_s;
    phase_e      nph_s;
    logic        tick_s;
    logic        last_clk_s;
    logic        wrap_s;
    logic        act_nxt_s;

    bus_state_e  state_r,    state_nxt_s;
    logic [11:0] addr_r,     addr_nxt_s;
    logic        wr_r,       wr_nxt_s;
    logic [3:0]  wdata_r,    wdata_nxt_s;
    logic [3:0]  opr_r,      opr_nxt_s;
    logic [3:0]  opa_r,      opa_nxt_s;
    logic        ack_r,      ack_nxt_s;
    logic        busy_r,     busy_nxt_s;
    logic        done_r,     done_nxt_s;
    logic [7:0]  rdata_r,    rdata_nxt_s;
    logic        sync_r,     sync_nxt_s;
    logic        cm_rom_r,   cm_rom_nxt_s;
    logic [3:0]  data_out_r, data_out_nxt_s;
    logic        data_oe_r,  data_oe_nxt_s;

    i4004_phase_gen #(
        .PHASE_DIV (PHASE_DIV)
    ) u_phase_gen (
        .CLK      (CLK),
        .RESET    (RESET),
        .phase    (phase_s),
        .tick     (tick_s),
        .last_clk (last_clk_s),
        .wrap     (wrap_s)
    );

    // Next-state: accept at cycle boundary, sample M1/M2, precompute drive for the phase being entered.
    always_comb begin
        state_nxt_s    = state_r;
        addr_nxt_s     = addr_r;
        wr_nxt_s       = wr_r;
        wdata_nxt_s    = wdata_r;
        opr_nxt_s      = opr_r;
        opa_nxt_s      = opa_r;
        ack_nxt_s      = 1'b0;
        done_nxt_s     = 1'b0;
        rdata_nxt_s    = rdata_r;
        busy_nxt_s     = busy_r;
        sync_nxt_s     = sync_r;
        cm_rom_nxt_s   = cm_rom_r;
        data_out_nxt_s = data_out_r;
        data_oe_nxt_s  = data_oe_r;
        nph_s          = wrap_s ? PH_A1 : next_phase(phase_s);

        if (last_clk_s && (state_r == ST_ACTIVE)) begin
            case (phase_s)
                PH_M1:   opr_nxt_s = data_in;
                PH_M2:   opa_nxt_s = data_in;
                default: begin
                    opr_nxt_s = opr_r;
                    opa_nxt_s = opa_r;
                end
            endcase
        end else begin
            opr_nxt_s = opr_r;
            opa_nxt_s = opa_r;
        end

        if (wrap_s) begin
            done_nxt_s = (state_r == ST_ACTIVE);
            if (state_r == ST_ACTIVE) begin
                rdata_nxt_s = {opr_r, opa_r};
            end else begin
                rdata_nxt_s = rdata_r;
            end
            if (req) begin
                state_nxt_s = ST_ACTIVE;
                addr_nxt_s  = addr;
                wr_nxt_s    = wr;
                wdata_nxt_s = wdata;
                ack_nxt_s   = 1'b1;
            end else begin
                state_nxt_s = ST_IDLE;
            end
        end else begin
            done_nxt_s = 1'b0;
        end

        act_nxt_s = (state_nxt_s == ST_ACTIVE);

        // Outputs are registered, so they are set up on the edge that enters the new phase.
        if (tick_s) begin
            busy_nxt_s   = act_nxt_s;
            sync_nxt_s   = (nph_s == PH_X3);
            cm_rom_nxt_s = act_nxt_s && (nph_s == PH_A3);
            case (nph_s)
                PH_A1, PH_A2, PH_A3: begin
                    data_oe_nxt_s  = act_nxt_s;
                    data_out_nxt_s = act_nxt_s ? addr_nibble(addr_nxt_s, nph_s) : 4'd0;
                end
                PH_X2: begin
                    data_oe_nxt_s  = act_nxt_s && wr_nxt_s;
                    data_out_nxt_s = (act_nxt_s && wr_nxt_s) ? wdata_nxt_s : 4'd0;
                end
                default: begin
                    data_oe_nxt_s  = 1'b0;
                    data_out_nxt_s = 4'd0;
                end
            endcase
        end else begin
            busy_nxt_s     = busy_r;
            sync_nxt_s     = sync_r;
            cm_rom_nxt_s   = cm_rom_r;
            data_oe_nxt_s  = data_oe_r;
            data_out_nxt_s = data_out_r;
        end
    end

    // State and output registers; reset drops any cycle in flight.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r    <= ST_IDLE;
            addr_r     <= 12'd0;
            wr_r       <= 1'b0;
            wdata_r    <= 4'd0;
            opr_r      <= 4'd0;
            opa_r      <= 4'd0;
            ack_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rdata_r    <= 8'd0;
            sync_r     <= 1'b0;
            cm_rom_r   <= 1'b0;
            data_out_r <= 4'd0;
            data_oe_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            addr_r     <= addr_nxt_s;
            wr_r       <= wr_nxt_s;
            wdata_r    <= wdata_nxt_s;
            opr_r      <= opr_nxt_s;
            opa_r      <= opa_nxt_s;
            ack_r      <= ack_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            rdata_r    <= rdata_nxt_s;
            sync_r     <= sync_nxt_s;
            cm_rom_r   <= cm_rom_nxt_s;
            data_out_r <= data_out_nxt_s;
            data_oe_r  <= data_oe_nxt_s;
        end
    end

    assign ack      = ack_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign rdata    = rdata_r;
    assign sync     = sync_r;
    assign cm_rom   = cm_rom_r;
    assign data_out = data_out_r;
    assign data_oe  = data_oe_r;

endmodule

// File: tb/tb_i4004_bus_master.sv
// Directed bench for i4004_bus_master: one instance at PHASE_DIV=1 and one at PHASE_DIV=4,
// with the bench acting as ROM responder and checking every CLK of each cycle.
module tb_i4004_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_v;
    logic        sel;
    logic        wr;
    logic [11:0] addr;
    logic [3:0]  wdata;
    logic [3:0]  data_in;
    logic        req1, req4;

    logic        ack1, busy1, done1, sync1, cm1, oe1;
    logic [7:0]  rd1;
    logic [3:0]  do1;
    logic        ack4, busy4, done4, sync4, cm4, oe4;
    logic [7:0]  rd4;
    logic [3:0]  do4;

    logic        v_ack, v_busy, v_done, v_sync, v_cm, v_oe;
    logic [7:0]  v_rd;
    logic [3:0]  v_do;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          div = 1;
    logic [7:0]  exp_rd;
    logic [7:0]  exp_rd_d1;

    always #5 clk = ~clk;

    assign req1 = req_v & ~sel;
    assign req4 = req_v & sel;

    i4004_bus_master #(.PHASE_DIV(1)) u_dut1 (
        .CLK(clk), .RESET(reset), .req(req1), .wr(wr), .addr(addr), .wdata(wdata),
        .ack(ack1), .busy(busy1), .done(done1), .rdata(rd1), .sync(sync1), .cm_rom(cm1),
        .data_out(do1), .data_oe(oe1), .data_in(data_in)
    );

    i4004_bus_master #(.PHASE_DIV(4)) u_dut4 (
        .CLK(clk), .RESET(reset), .req(req4), .wr(wr), .addr(addr), .wdata(wdata),
        .ack(ack4), .busy(busy4), .done(done4), .rdata(rd4), .sync(sync4), .cm_rom(cm4),
        .data_out(do4), .data_oe(oe4), .data_in(data_in)
    );

    always_comb begin
        if (sel) begin
            v_ack = ack4; v_busy = busy4; v_done = done4; v_sync = sync4;
            v_cm = cm4; v_oe = oe4; v_rd = rd4; v_do = do4;
        end else begin
            v_ack = ack1; v_busy = busy1; v_done = done1; v_sync = sync1;
            v_cm = cm1; v_oe = oe1; v_rd = rd1; v_do = do1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic wait_ack();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 20 * div && !seen; k++) begin
            @(negedge clk);
            if (v_ack) seen = 1'b1;
        end
        chk("ack_seen", {31'd0, seen}, 32'd1);
    endtask

    // Entered at the negedge where ack is high; leaves at the negedge where done is high.
    task automatic body(input logic [11:0] a, input logic w, input logic [3:0] wd,
                        input logic [7:0] rb, input logic hold, input logic [11:0] na,
                        input logic nw, input logic [3:0] nwd);
        int   ph;
        logic last;
        logic exp_oe;
        logic [3:0] exp_do;
        req_v = hold; addr = na; wr = nw; wdata = nwd;
        for (int i = 0; i < 8 * div; i++) begin
            ph   = i / div;
            last = ((i % div) == (div - 1));
            exp_oe = (ph < 3) || ((ph == 6) && w);
            case (ph)
                0:       exp_do = a[3:0];
                1:       exp_do = a[7:4];
                2:       exp_do = a[11:8];
                default: exp_do = wd;
            endcase
            chk("busy", {31'd0, v_busy}, 32'd1);
            chk("sync", {31'd0, v_sync}, {31'd0, ph == 7});
            chk("cm_rom", {31'd0, v_cm}, {31'd0, ph == 2});
            chk("data_oe", {31'd0, v_oe}, {31'd0, exp_oe});
            if (exp_oe) chk("data_out", {28'd0, v_do}, {28'd0, exp_do});
            if (i > 0) chk("ack_once", {31'd0, v_ack}, 32'd0);
            if (i > 0) chk("done_early", {31'd0, v_done}, 32'd0);
            chk("rdata_stable", {24'd0, v_rd}, {24'd0, exp_rd});
            case (ph)
                3:       data_in = last ? rb[7:4] : ~rb[7:4];
                4:       data_in = last ? rb[3:0] : ~rb[3:0];
                default: data_in = ~rb[3:0];
            endcase
            @(negedge clk);
        end
        exp_rd = rb;
        chk("done", {31'd0, v_done}, 32'd1);
        chk("rdata", {24'd0, v_rd}, {24'd0, exp_rd});
        chk("ack_b2b", {31'd0, v_ack}, {31'd0, hold});
    endtask

    initial begin
        reset = 1'b1; req_v = 1'b0; sel = 1'b0; wr = 1'b0;
        addr = 12'd0; wdata = 4'd0; data_in = 4'd0; exp_rd = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, v_ack}, 32'd0);
        chk("rst_busy", {31'd0, v_busy}, 32'd0);
        chk("rst_done", {31'd0, v_done}, 32'd0);
        chk("rst_sync", {31'd0, v_sync}, 32'd0);
        chk("rst_cm", {31'd0, v_cm}, 32'd0);
        chk("rst_oe", {31'd0, v_oe}, 32'd0);
        chk("rst_do", {28'd0, v_do}, 32'd0);
        chk("rst_rdata", {24'd0, v_rd}, 32'd0);
        chk("rst_sync4", {31'd0, sync4}, 32'd0);
        reset = 1'b0;

        // 1: single read, first tick after reset
        req_v = 1'b1; addr = 12'h3A5; wr = 1'b0;
        wait_ack();
        body(12'h3A5, 1'b0, 4'h0, 8'hD7, 1'b0, 12'h000, 1'b0, 4'h0);

        // 2: three back-to-back requests
        req_v = 1'b1; addr = 12'h000;
        wait_ack();
        body(12'h000, 1'b0, 4'h0, 8'h12, 1'b1, 12'h001, 1'b0, 4'h0);
        body(12'h001, 1'b0, 4'h0, 8'h34, 1'b1, 12'hFFF, 1'b0, 4'h0);
        body(12'hFFF, 1'b0, 4'h0, 8'hEF, 1'b0, 12'h000, 1'b0, 4'h0);

        // 4: port write; inputs change right after ack to prove they were latched
        req_v = 1'b1; addr = 12'h0C3; wr = 1'b1; wdata = 4'h9;
        wait_ack();
        body(12'h0C3, 1'b1, 4'h9, 8'h81, 1'b0, 12'h000, 1'b0, 4'h0);

        // 3: idle bus keeps cycling
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            chk("idle_sync", {31'd0, v_sync}, {31'd0, (i % 8) == 7});
            chk("idle_oe", {31'd0, v_oe}, 32'd0);
            chk("idle_cm", {31'd0, v_cm}, 32'd0);
            chk("idle_ack", {31'd0, v_ack}, 32'd0);
            chk("idle_done", {31'd0, v_done}, 32'd0);
            chk("idle_busy", {31'd0, v_busy}, 32'd0);
        end

        // 5: PHASE_DIV=4 instance
        exp_rd_d1 = exp_rd;
        sel = 1'b1; div = 4; exp_rd = 8'h00;
        req_v = 1'b1; addr = 12'h1C2; wr = 1'b0;
        wait_ack();
        body(12'h1C2, 1'b0, 4'h0, 8'hA6, 1'b0, 12'h000, 1'b0, 4'h0);

        // 6: reset during M1 of an active cycle
        sel = 1'b0; div = 1; exp_rd = exp_rd_d1;
        req_v = 1'b1; addr = 12'h2B6; wr = 1'b0;
        wait_ack();
        req_v = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", {31'd0, v_busy}, 32'd1);
        data_in = 4'h5;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ack", {31'd0, v_ack}, 32'd0);
        chk("mid_rst_busy", {31'd0, v_busy}, 32'd0);
        chk("mid_rst_done", {31'd0, v_done}, 32'd0);
        chk("mid_rst_sync", {31'd0, v_sync}, 32'd0);
        chk("mid_rst_cm", {31'd0, v_cm}, 32'd0);
        chk("mid_rst_oe", {31'd0, v_oe}, 32'd0);
        chk("mid_rst_do", {28'd0, v_do}, 32'd0);
        chk("mid_rst_rdata", {24'd0, v_rd}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_rd = 8'h00;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_rst_done", {31'd0, v_done}, 32'd0);
            chk("post_rst_busy", {31'd0, v_busy}, 32'd0);
            chk("post_rst_rdata", {24'd0, v_rd}, 32'd0);
        end
        req_v = 1'b1; addr = 12'h7E1; wr = 1'b0;
        wait_ack();
        body(12'h7E1, 1'b0, 4'h0, 8'h6C, 1'b0, 12'h000, 1'b0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
